// File: rtl/fp32_to_fixed_pkg.sv
// Shared FP32 field definitions and the stage-1 payload of the float-to-fixed converter.
package fp32_to_fixed_pkg;

  localparam int unsigned FP_EXP_BIAS = 127;
  localparam int unsigned FP_MAN_W    = 23;
  localparam int unsigned FP_EXP_W    = 8;
  localparam int unsigned FP_EXP_MAX  = (1 << FP_EXP_W) - 1;

  // Two's-complement shift amount k = e - 150 + FRAC_BITS spans roughly -149..150.
  localparam int unsigned K_W = 10;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_fields_t;

  typedef struct packed {
    logic              sign;
    logic [K_W-1:0]    k;
    logic [FP_MAN_W:0] man;
    logic              exc;
    logic              zero;
  } fx_stage1_t;

endpackage

// File: rtl/fx_shift_sat.sv
// Combinational shift / negate / overflow clamp of a {1,m} mantissa into OUT_W-bit fixed point.
// FP32_TO_FIXED_SATURATE_EN selects saturation on overflow; otherwise the result wraps.
module fx_shift_sat
  import fp32_to_fixed_pkg::*;
#(
  parameter int unsigned OUT_W = 32
) (
  input  logic              sign,
  input  logic [K_W-1:0]    k,
  input  logic [FP_MAN_W:0] man,
  input  logic              exc,
  input  logic              zero,
  output logic [OUT_W-1:0]  out,
  output logic              ovf
);

  localparam int unsigned MAN_W = FP_MAN_W + 1;
  localparam int unsigned MW    = OUT_W + MAN_W;
  localparam logic [MW-1:0] HALF = MW'(1) << (OUT_W - 1);

  logic [K_W-1:0]   sh;
  logic [MW-1:0]    mag;
  logic             big;
  logic [OUT_W-1:0] res;

  always_comb begin
    sh  = '0;
    mag = '0;
    big = 1'b0;
    res = '0;
    out = '0;
    ovf = 1'b0;

    // Left shifts of OUT_W or more always overflow and leave the low OUT_W bits zero.
    if (!k[K_W-1]) begin
      sh = k;
      if (sh >= K_W'(OUT_W)) big = 1'b1;
      else                   mag = MW'(man) << sh;
    end else begin
      sh = -k;
      if (sh < K_W'(MAN_W)) mag = MW'(man) >> sh;
    end

    ovf = big | (sign ? (mag > HALF) : (mag >= HALF));
    res = sign ? -mag[OUT_W-1:0] : mag[OUT_W-1:0];

`ifdef FP32_TO_FIXED_SATURATE_EN
    if (ovf) out = sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    else     out = res;
`else
    out = res;
`endif

    if (exc || zero) begin
      out = '0;
      ovf = 1'b0;
    end
  end

endmodule

// File: rtl/fp32_to_fixed.sv
// Two-stage valid/ready FP32 to signed fixed-point converter (truncate toward zero).
// Build option FP32_TO_FIXED_SATURATE_EN clamps overflowing results instead of wrapping.
module fp32_to_fixed
  import fp32_to_fixed_pkg::*;
#(
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      InA,
  input  logic             InValid,
  output logic             InReady,
  output logic [OUT_W-1:0] Out,
  output logic             OutValid,
  input  logic             OutReady,
  output logic             Ovf,
  output logic             Exc
);

  localparam int unsigned K_OFS = FP_EXP_BIAS + FP_MAN_W;

  fp32_fields_t     fld;
  fx_stage1_t       s1_d;
  fx_stage1_t       s1_q;
  logic             s1_valid;
  logic             s2_free;
  logic             s1_adv;
  logic             accept;
  logic [OUT_W-1:0] fx_out;
  logic             fx_ovf;

  assign fld     = fp32_fields_t'(InA);
  assign s2_free = !OutValid || OutReady;
  assign s1_adv  = s1_valid && s2_free;
  assign InReady = !rst && (!s1_valid || s1_adv);
  assign accept  = InValid && InReady;

  // Field decode into the stage-1 payload.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = fld.sign;
    s1_d.k    = K_W'(fld.exp) - K_W'(K_OFS) + K_W'(FRAC_BITS);
    s1_d.man  = {1'b1, fld.man};
    s1_d.exc  = (fld.exp == FP_EXP_W'(FP_EXP_MAX));
    s1_d.zero = (fld.exp == '0);
  end

  fx_shift_sat #(
    .OUT_W(OUT_W)
  ) u_shift_sat (
    .sign (s1_q.sign),
    .k    (s1_q.k),
    .man  (s1_q.man),
    .exc  (s1_q.exc),
    .zero (s1_q.zero),
    .out  (fx_out),
    .ovf  (fx_ovf)
  );

  // Stage 2 only reloads when empty or being drained, so held results stay stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
      OutValid <= 1'b0;
      Out      <= '0;
      Ovf      <= 1'b0;
      Exc      <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_q     <= s1_d;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s2_free) begin
        OutValid <= s1_valid;
        if (s1_valid) begin
          Out <= fx_out;
          Ovf <= fx_ovf;
          Exc <= s1_q.exc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp32_to_fixed.sv
// Self-checking bench for fp32_to_fixed (OUT_W=32, FRAC_BITS=16) with a queue scoreboard.
module tb_fp32_to_fixed;

  localparam int unsigned OUT_W     = 32;
  localparam int unsigned FRAC_BITS = 16;
  localparam int          NV        = 11;

`ifdef FP32_TO_FIXED_SATURATE_EN
  localparam logic [31:0] POS_OVF_OUT = 32'h7FFFFFFF;
  localparam logic [31:0] NEG_OVF_OUT = 32'h80000000;
`else
  localparam logic [31:0] POS_OVF_OUT = 32'h00000000;
  localparam logic [31:0] NEG_OVF_OUT = 32'h7FFF0000;
`endif

  typedef struct packed {
    logic [31:0] out;
    logic        ovf;
    logic        exc;
  } exp_t;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic [31:0] in_a      = '0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [31:0] out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        ovf;
  logic        exc;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  fp32_to_fixed #(
    .OUT_W    (OUT_W),
    .FRAC_BITS(FRAC_BITS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .InA     (in_a),
    .InValid (in_valid),
    .InReady (in_ready),
    .Out     (out),
    .OutValid(out_valid),
    .OutReady(out_ready),
    .Ovf     (ovf),
    .Exc     (exc)
  );

  always #5 clk = ~clk;

  // Reference: exact magnitude in 64 bits, truncate, negate, then overflow policy.
  function automatic exp_t model(input logic [31:0] a);
    exp_t        r;
    int          e;
    int          k;
    logic [63:0] mag;
    logic        big;
    r   = '0;
    e   = int'(a[30:23]);
    k   = e - 150 + int'(FRAC_BITS);
    mag = {40'h0, 1'b1, a[22:0]};
    big = 1'b0;
    if (e == 0) return r;
    if (e == 255) begin
      r.exc = 1'b1;
      return r;
    end
    if (k >= 40) begin
      big = 1'b1;
      mag = '0;
    end else if (k >= 0) begin
      mag = mag << k;
    end else if (-k >= 24) begin
      mag = '0;
    end else begin
      mag = mag >> (-k);
    end
    r.ovf = big || (a[31] ? (mag > 64'h80000000) : (mag >= 64'h80000000));
    r.out = a[31] ? (32'h0 - mag[31:0]) : mag[31:0];
`ifdef FP32_TO_FIXED_SATURATE_EN
    if (r.ovf) r.out = a[31] ? 32'h80000000 : 32'h7FFFFFFF;
`endif
    return r;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [7:0] e;
    int         r;
    r = int'($urandom_range(0, 19));
    if (r == 0)      e = 8'h00;
    else if (r == 1) e = 8'hFF;
    else             e = 8'($urandom_range(100, 175));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h want 00000000", out); end
    checks++; if ({ovf, exc} !== 2'b00) begin errors++; $display("FAIL reset_flags: got ovf=%b exc=%b want 0 0", ovf, exc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  // Single operands with OutReady high: latency, result and flags.
  task automatic test_vectors();
    logic [31:0] va[NV] = '{32'h3F800000, 32'hC0200000, 32'h37000000, 32'h80000000,
                            32'h47800000, 32'hC7000000, 32'h7F800000, 32'h7FC00000,
                            32'h00000001, 32'hC7000100, 32'h46FFFFFE};
    exp_t ve[NV] = '{{32'h00010000, 1'b0, 1'b0}, {32'hFFFD8000, 1'b0, 1'b0},
                     {32'h00000000, 1'b0, 1'b0}, {32'h00000000, 1'b0, 1'b0},
                     {POS_OVF_OUT,  1'b1, 1'b0}, {32'h80000000, 1'b0, 1'b0},
                     {32'h00000000, 1'b0, 1'b1}, {32'h00000000, 1'b0, 1'b1},
                     {32'h00000000, 1'b0, 1'b0}, {NEG_OVF_OUT,  1'b1, 1'b0},
                     {32'h7FFFFF00, 1'b0, 1'b0}};
    exp_t e;
    sb.delete();
    for (int i = 0; i < NV; i++) begin
      @(negedge clk); in_a = va[i]; in_valid = 1'b1; out_ready = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL vec_in_ready[%0d]: got %b want 1", i, in_ready); end
      sb.push_back(ve[i]);
      @(negedge clk); in_valid = 1'b0; #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL vec_early_valid[%0d]: got %b want 0", i, out_valid); end
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL vec_latency[%0d]: out_valid got %b want 1 two cycles after input", i, out_valid);
      end else begin
        e = sb.pop_front();
        checks++;
        if ({out, ovf, exc} !== e) begin
          errors++;
          $display("FAIL vec_result[%0d] in=%h: got out=%h ovf=%b exc=%b want out=%h ovf=%b exc=%b",
                   i, va[i], out, ovf, exc, e.out, e.ovf, e.exc);
        end
      end
    end
    sb.delete();
  endtask

  // Streaming with optional random stalls on both sides, checked against the model.
  task automatic test_back_to_back(input int n, input int stall_pct, input string tag);
    int          sent = 0;
    int          got  = 0;
    int          cyc  = 0;
    exp_t        e;
    logic [31:0] a;
    sb.delete();
    a = rand_operand();
    while ((sent < n || got < sent) && cyc < 4000) begin
      @(negedge clk); cyc++;
      in_valid  = (sent < n) && ($urandom_range(0, 99) >= 32'(stall_pct));
      in_a      = a;
      out_ready = ($urandom_range(0, 99) >= 32'(stall_pct));
      #1;
      if (out_valid && out_ready) begin
        got++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL %s_unexpected: got out=%h with empty scoreboard", tag, out);
        end else begin
          e = sb.pop_front();
          if ({out, ovf, exc} !== e) begin
            errors++;
            $display("FAIL %s_result #%0d: got out=%h ovf=%b exc=%b want out=%h ovf=%b exc=%b",
                     tag, got, out, ovf, exc, e.out, e.ovf, e.exc);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(a));
        sent++;
        a = rand_operand();
      end
    end
    in_valid = 1'b0;
    checks++; if (got != n) begin errors++; $display("FAIL %s_count: got %0d results want %0d (cycles %0d)", tag, got, n, cyc); end
    if (stall_pct == 0) begin
      checks++; if (cyc != n + 2) begin errors++; $display("FAIL %s_throughput: got %0d cycles want %0d", tag, cyc, n + 2); end
    end
    sb.delete();
  endtask

  task automatic test_backpressure();
    logic [31:0] items[3] = '{32'h3F800000, 32'h40000000, 32'h40400000};
    exp_t        iexp[3]  = '{{32'h00010000, 1'b0, 1'b0}, {32'h00020000, 1'b0, 1'b0},
                              {32'h00030000, 1'b0, 1'b0}};
    int          idx = 0;
    int          got = 0;
    int          cyc = 0;
    exp_t        e;
    sb.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); out_ready = 1'b0; in_valid = (idx < 3); in_a = (idx < 3) ? items[idx] : 32'h0; #1;
      if (c >= 2) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
        checks++; if (out_valid !== 1'b1 || out !== 32'h00010000) begin
          errors++; $display("FAIL bp_hold[%0d]: got valid=%b out=%h want valid=1 out=00010000", c, out_valid, out);
        end
      end
      if (in_valid && in_ready) begin sb.push_back(iexp[idx]); idx++; end
    end
    checks++; if (idx != 2) begin errors++; $display("FAIL bp_accepts: got %0d accepts want 2", idx); end
    while (got < 3 && cyc < 50) begin
      @(negedge clk); cyc++; out_ready = 1'b1;
      in_valid = (idx < 3); in_a = (idx < 3) ? items[idx] : 32'h0; #1;
      if (out_valid && out_ready) begin
        got++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bp_unexpected: got out=%h with empty scoreboard", out);
        end else begin
          e = sb.pop_front();
          if ({out, ovf, exc} !== e) begin errors++; $display("FAIL bp_order #%0d: got out=%h want out=%h", got, out, e.out); end
        end
      end
      if (in_valid && in_ready) begin sb.push_back(iexp[idx]); idx++; end
    end
    in_valid = 1'b0;
    checks++; if (got != 3) begin errors++; $display("FAIL bp_drain: got %0d results want 3", got); end
    sb.delete();
  endtask

  task automatic test_mid_reset();
    int stale = 0;
    out_ready = 1'b0;
    @(negedge clk); in_a = 32'h3F800000; in_valid = 1'b1;
    @(negedge clk); in_a = 32'h40000000; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0; #1;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mrst_setup: got valid=%b ready=%b want 1 0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_flush: got out_valid=%b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0 || out !== 32'h0) begin
      errors++; $display("FAIL mrst_state: got ready=%b out=%h want 0 00000000", in_ready, out);
    end
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready: got %b want 1", in_ready); end
    repeat (6) begin
      @(negedge clk); #1;
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL mrst_stale: got %0d stale valid cycles want 0", stale); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back(24, 0, "b2b");
    test_back_to_back(60, 35, "stall");
    test_backpressure();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
